mmio_uart_tx: RTL and testbench

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

---
 rtl/mmio_uart_pkg.sv | 31 +++
 rtl/mmio_uart_tx_fifo.sv | 53 +++++
 rtl/mmio_uart_tx.sv | 178 +++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS bit positions, access sizes and transmitter state encoding.
package mmio_uart_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_access_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_t;

  localparam logic [3:0] OFF_TXDATA = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_CTRL   = 4'h8;
  localparam logic [3:0] OFF_LIMIT  = 4'hC;

  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_BUSY    = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 8;

  localparam int FRAME_BITS = 10;

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Byte FIFO feeding the UART shifter. Push is ignored when full and pop when
// empty, both judged on the state at the start of the cycle.
module tx_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [7:0]                 wr_data,
  output logic [7:0]                 rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO and sticky overflow flag.
// Define MMIO_UART_TX_PRINT_EN to echo accepted bytes to the simulator console.
//
// state   | meaning
// S_IDLE  | line high, waiting for a byte in the FIFO
// S_START | start bit (tx low)
// S_DATA  | eight data bits, LSB first
// S_STOP  | stop bit (tx high), then next byte or idle
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'hF000_0000,
  parameter int          CLKS_PER_BIT = 4,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wr_data,
  input  logic        mem_wr_ena,
  input  mem_access_t mem_access,
  output logic [31:0] mem_rd_data,
  output logic        bus_error,
  output logic        tx
);

  localparam int CCW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CCW-1:0] CYC_LAST = CCW'(CLKS_PER_BIT - 1);
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  tx_state_t      state;
  logic [CCW-1:0] cyc_cnt;
  logic [2:0]     bit_cnt;
  logic [7:0]     shreg;
  logic           overflow;

  logic           sel;
  logic [3:0]     off;
  logic           acc_ok;
  logic           wr_txdata;
  logic           wr_ctrl;
  logic           push_req;
  logic           push;
  logic           pop;
  logic           bit_done;
  logic [31:0]    status;

  logic [7:0]     fifo_head;
  logic           fifo_full;
  logic           fifo_empty;
  logic [FCW-1:0] fifo_count;

  logic           unused_bits;
  assign unused_bits = ^{mem_access, mem_wr_data[31:8]};

  assign sel       = (mem_addr[31:4] == BASE_ADDR[31:4]);
  assign off       = mem_addr[3:0];
  assign bus_error = sel && ((off[1:0] != 2'b00) || (off >= OFF_LIMIT));
  assign acc_ok    = sel && !bus_error;

  assign wr_txdata = acc_ok && mem_wr_ena && (off == OFF_TXDATA);
  assign wr_ctrl   = acc_ok && mem_wr_ena && (off == OFF_CTRL);
  assign push_req  = wr_txdata && ena;
  assign push      = push_req && !fifo_full;

  assign bit_done  = (cyc_cnt == '0);
  assign pop       = ena && !fifo_empty &&
                     ((state == S_IDLE) || ((state == S_STOP) && bit_done));

  always_comb begin
    status                           = '0;
    status[STAT_FULL]                = fifo_full;
    status[STAT_EMPTY]               = fifo_empty;
    status[STAT_BUSY]                = (state != S_IDLE);
    status[STAT_OVF]                 = overflow;
    status[STAT_CNT_LSB +: 8]        = 8'(fifo_count);
  end

  assign mem_rd_data = (acc_ok && (off == OFF_STATUS)) ? status : 32'h0;

  tx_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data (mem_wr_data[7:0]),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // A set in the same cycle as a clear wins so no drop goes unreported.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (ena) begin
      if (push_req && fifo_full)
        overflow <= 1'b1;
      else if (wr_ctrl && mem_wr_data[0])
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cyc_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (ena) begin
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            shreg   <= fifo_head;
            cyc_cnt <= CYC_LAST;
            state   <= S_START;
          end
        end
        S_START: begin
          if (bit_done) begin
            cyc_cnt <= CYC_LAST;
            bit_cnt <= 3'd7;
            state   <= S_DATA;
          end else begin
            cyc_cnt <= cyc_cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (bit_done) begin
            cyc_cnt <= CYC_LAST;
            shreg   <= {1'b0, shreg[7:1]};
            if (bit_cnt == '0)
              state <= S_STOP;
            else
              bit_cnt <= bit_cnt - 1'b1;
          end else begin
            cyc_cnt <= cyc_cnt - 1'b1;
          end
        end
        S_STOP: begin
          if (bit_done) begin
            if (!fifo_empty) begin
              shreg   <= fifo_head;
              cyc_cnt <= CYC_LAST;
              state   <= S_START;
            end else begin
              cyc_cnt <= '0;
              state   <= S_IDLE;
            end
          end else begin
            cyc_cnt <= cyc_cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    case (state)
      S_START: tx = 1'b0;
      S_DATA:  tx = shreg[0];
      default: tx = 1'b1;
    endcase
  end

`ifdef MMIO_UART_TX_PRINT_EN
  always @(posedge clk) begin
    if (!rst && push) $write("%c", mem_wr_data[7:0]);
  end
`else
`endif

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Randomized bench for mmio_uart_tx against a frame-timeline reference model,
// with directed sequences for framing, overflow, decode and reset abort.
module tb_mmio_uart_tx;
  import mmio_uart_pkg::*;

  localparam logic [31:0] BASE  = 32'hF000_0000;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 8;
  localparam int          FRAME = FRAME_BITS * CPB;

  logic        clk = 1'b0;
  logic        rst, ena, mem_wr_ena, bus_error, tx;
  logic [31:0] mem_addr, mem_wr_data, mem_rd_data;
  mem_access_t mem_access;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: pending bytes, current frame byte, cycles left in frame.
  logic [7:0] m_q[$];
  logic [7:0] m_cur;
  int         m_rem;
  bit         m_ovf;
  logic [31:0] obs_rd;

  mmio_uart_tx #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_wr_ena  (mem_wr_ena),
    .mem_access  (mem_access),
    .mem_rd_data (mem_rd_data),
    .bus_error   (bus_error),
    .tx          (tx)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_sel(input logic [31:0] a);
    return a[31:4] == BASE[31:4];
  endfunction

  function automatic bit m_err(input logic [31:0] a);
    int o;
    o = int'(a[3:0]);
    return m_sel(a) && ((o % 4) != 0 || o >= 12);
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = 32'h0;
    s[15:8] = 8'(m_q.size());
    s[3] = m_ovf;
    s[2] = (m_rem != 0);
    s[1] = (m_q.size() == 0);
    s[0] = (m_q.size() == DEPTH);
    return s;
  endfunction

  function automatic logic m_tx();
    int b;
    if (m_rem == 0) return 1'b1;
    b = (FRAME - m_rem) / CPB;
    if (b == 0) return 1'b0;
    if (b == FRAME_BITS - 1) return 1'b1;
    return m_cur[b-1];
  endfunction

  // One clock: drive at negedge, check outputs, then advance the model at posedge.
  task automatic cycle(input bit r, input bit e, input bit w,
                       input logic [31:0] a, input logic [31:0] d);
    bit ok, full0, empty0, preq;
    logic [31:0] exp_rd;
    @(negedge clk);
    rst = r; ena = e; mem_wr_ena = w; mem_addr = a; mem_wr_data = d;
    #1;
    ok = m_sel(a) && !m_err(a);
    exp_rd = (ok && a[3:0] == 4'h4) ? m_status() : 32'h0;
    obs_rd = mem_rd_data;
    check_val("tx", {31'h0, tx}, {31'h0, m_tx()});
    check_val("rd_data", mem_rd_data, exp_rd);
    check_val("bus_error", {31'h0, bus_error}, {31'h0, m_err(a)});
    @(posedge clk);
    if (r) begin
      m_q.delete(); m_rem = 0; m_ovf = 1'b0;
    end else if (e) begin
      full0  = (m_q.size() == DEPTH);
      empty0 = (m_q.size() == 0);
      if (m_rem <= 1 && !empty0) begin
        m_cur = m_q.pop_front();
        m_rem = FRAME;
      end else if (m_rem > 0) begin
        m_rem--;
      end
      preq = w && ok && a[3:0] == 4'h0;
      if (preq && !full0) m_q.push_back(d[7:0]);
      if (preq && full0) m_ovf = 1'b1;
      else if (w && ok && a[3:0] == 4'h8 && d[0]) m_ovf = 1'b0;
    end
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cycle(0, 1, 0, BASE + 32'h4, 32'h0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((m_q.size() != 0 || m_rem != 0) && k < 2000) begin
      idle_n(1);
      k++;
    end
    check_val("drain_bound", {31'h0, (k < 2000)}, 32'h1);
  endtask

  initial begin
    int busy_sum, k;
    logic [31:0] addr_tab [10];
    addr_tab = '{BASE, BASE, BASE, BASE + 32'h4, BASE + 32'h8, BASE + 32'h2,
                 BASE + 32'hC, BASE + 32'h10, BASE + 32'h1, 32'h1234_5670};
    mem_access = MEM_WORD;
    rst = 1; ena = 1; mem_wr_ena = 0; mem_addr = 0; mem_wr_data = 0;
    m_rem = 0; m_ovf = 0; m_cur = 0;
    repeat (2) @(posedge clk);

    // Reset state
    cycle(1, 1, 0, BASE + 32'h4, 0);
    cycle(0, 1, 0, BASE + 32'h4, 0);
    check_val("reset_status", obs_rd, 32'h0000_0002);
    check_val("reset_tx", {31'h0, tx}, 32'h1);

    // Single frame of 0x41
    cycle(0, 1, 1, BASE, 32'h0000_0041);
    idle_n(FRAME + 5);

    // Overflow with ten stores, then clear
    for (int i = 0; i < 10; i++) cycle(0, 1, 1, BASE, 32'h30 + i);
    cycle(0, 1, 0, BASE + 32'h4, 0);
    check_val("ovf_status", obs_rd, 32'h0000_080D);
    cycle(0, 1, 1, BASE + 32'h8, 32'h1);
    cycle(0, 1, 0, BASE + 32'h4, 0);
    check_val("ovf_clear", obs_rd, 32'h0000_0805);
    drain();

    // Back-to-back 0x55, 0xAA
    cycle(0, 1, 1, BASE, 32'h55);
    cycle(0, 1, 1, BASE, 32'hAA);
    busy_sum = 0;
    for (int i = 0; i < 100; i++) begin
      cycle(0, 1, 0, BASE + 32'h4, 0);
      busy_sum += int'(obs_rd[2]);
    end
    check_val("b2b_busy_cycles", busy_sum, 80);

    // Decode errors
    cycle(0, 1, 1, BASE + 32'h2, 32'h77);
    check_val("err_off2", {31'h0, bus_error}, 32'h1);
    cycle(0, 1, 1, BASE + 32'hC, 32'h77);
    check_val("err_offC", {31'h0, bus_error}, 32'h1);
    cycle(0, 1, 0, BASE + 32'h10, 0);
    check_val("nosel_err", {31'h0, bus_error}, 32'h0);
    check_val("nosel_rd", obs_rd, 32'h0);
    cycle(0, 1, 0, BASE + 32'h4, 0);
    check_val("err_count", obs_rd, 32'h0000_0002);

    // Reset mid data bits of 0x0F
    cycle(0, 1, 1, BASE, 32'h0F);
    idle_n(12);
    cycle(1, 1, 0, BASE + 32'h4, 0);
    cycle(0, 1, 0, BASE + 32'h4, 0);
    check_val("abort_tx", {31'h0, tx}, 32'h1);
    check_val("abort_status", obs_rd, 32'h0000_0002);

    // Push on full coinciding with end-of-stop pop
    k = 0;
    while (m_q.size() < DEPTH && k < 20) begin
      cycle(0, 1, 1, BASE, 32'h60 + k);
      k++;
    end
    k = 0;
    while (m_rem != 1 && k < 200) begin
      idle_n(1);
      k++;
    end
    check_val("eos_bound", {31'h0, (k < 200)}, 32'h1);
    cycle(0, 1, 1, BASE, 32'hEE);
    cycle(0, 1, 0, BASE + 32'h4, 0);
    check_val("eos_status", obs_rd, 32'h0000_070C);
    drain();

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      bit r, e, w;
      logic [31:0] a, d;
      r = ($urandom_range(0, 499) == 0);
      e = ($urandom_range(0, 9) != 0);
      w = ($urandom_range(0, 3) == 0);
      a = addr_tab[$urandom_range(0, 9)];
      d = $urandom;
      cycle(r, e, w, a, d);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
